// File: rtl/error_sampler.sv
// rtl/error_sampler.sv - PID sample-rate front end: period tick, ADC request, saturated error and difference
// Paces one ADC conversion per DIV enabled cycles and turns each returned sample into ek/dek plus an en_k strobe.
module error_sampler #(
  parameter int W   = 12,
  parameter int DIV = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         clr_missed,
  input  logic [W-1:0] ref_in,
  input  logic [W-1:0] adc_data,
  input  logic         adc_valid,
  output logic         adc_start,
  output logic [W-1:0] ek,
  output logic [W-1:0] dek,
  output logic         en_k,
  output logic         missed
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, WAIT, CALC} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           adc_start_q, adc_start_d;
  logic           en_k_q, en_k_d;
  logic           missed_q, missed_d;
  logic [W-1:0]   ek_q, ek_d;
  logic [W-1:0]   dek_q, dek_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   r_q, r_d;
  logic           tick;
  logic [W:0]     diff_e;
  logic [W-1:0]   ek_new;
  logic [W:0]     diff_de;

  // Clamp a W+1 bit two's complement value into the W-bit signed range.
  function automatic logic [W-1:0] sat(input logic [W:0] v);
    if (v[W] != v[W-1]) begin
      sat = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat = v[W-1:0];
    end
  endfunction

  assign tick = enable && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    diff_e  = {r_q[W-1], r_q} - {y_q[W-1], y_q};
    ek_new  = sat(diff_e);
    diff_de = {ek_new[W-1], ek_new} - {ek_q[W-1], ek_q};
  end

  always_comb begin
    state_d     = state_q;
    adc_start_d = 1'b0;
    en_k_d      = 1'b0;
    missed_d    = missed_q & ~clr_missed;
    ek_d        = ek_q;
    dek_d       = dek_q;
    y_d         = y_q;
    r_d         = r_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = WAIT;
          adc_start_d = 1'b1;
        end
      end
      WAIT: begin
        // A returning sample takes priority over a period tick landing on the same edge.
        if (adc_valid) begin
          y_d     = adc_data;
          r_d     = ref_in;
          state_d = CALC;
        end else if (tick) begin
          missed_d    = 1'b1;
          adc_start_d = 1'b1;
        end
      end
      CALC: begin
        ek_d    = ek_new;
        dek_d   = sat(diff_de);
        en_k_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adc_start_q <= 1'b0;
      en_k_q      <= 1'b0;
      missed_q    <= 1'b0;
      ek_q        <= '0;
      dek_q       <= '0;
      y_q         <= '0;
      r_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adc_start_q <= adc_start_d;
      en_k_q      <= en_k_d;
      missed_q    <= missed_d;
      ek_q        <= ek_d;
      dek_q       <= dek_d;
      y_q         <= y_d;
      r_q         <= r_d;
    end
  end

  assign adc_start = adc_start_q;
  assign en_k      = en_k_q;
  assign missed    = missed_q;
  assign ek        = ek_q;
  assign dek       = dek_q;

endmodule

// File: doc/error_sampler.md
# error_sampler

Sample-rate front end of the PID loop. Paces the control period with a clock-divider tick and requests an ADC conversion on each tick. When the conversion returns it computes the saturated error ek = ref − yk and its first difference dek = ek − ek₋₁, then issues a one-cycle strobe (en_k) that drives the Enable of the downstream integrator and derivative stages. All data are W-bit two's complement.

## Interface
- W, 12, data width of ref, adc_data, ek, dek
- DIV, 100, control period in CLK cycles (≥ 4)
- CLK  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Enable  in  1  run gate for the sample timer
- clr_missed  in  1  synchronous clear of the missed flag
- ref  in  W  setpoint, signed
- adc_data  in  W  measured output yk, signed
- adc_valid  in  1  one-cycle strobe, adc_data valid
- adc_start  out  1  one-cycle conversion request
- ek  out  W  saturated error, registered
- dek  out  W  saturated ek − ek₋₁, registered
- en_k  out  1  one-cycle strobe: ek/dek just updated
- missed  out  1  sticky: conversion not returned within one period

## Operation
- Reset state: FSM IDLE, tick counter 0, adc_start 0, ek 0, dek 0, en_k 0, missed 0, internal y/ref capture registers 0.
- Tick counter:
  - Counts only while Enable is high. Holds value while Enable is low.
  - tick = (count == DIV−1) && Enable. On tick, count wraps to 0.
- FSM states IDLE, WAIT, CALC.
  - IDLE: on tick, go to WAIT and set adc_start = 1 for exactly the next cycle.
  - WAIT, adc_valid = 1: capture adc_data and ref into registers; go to CALC. adc_valid wins over a simultaneous tick, and missed is not set.
  - WAIT, tick without adc_valid: set missed, re-pulse adc_start next cycle, stay in WAIT.
  - CALC: compute and load outputs (see arithmetic); pulse en_k; return to IDLE unconditionally.
- adc_valid outside WAIT is ignored. Ticks during CALC are dropped; missed is not set.
- Enable low while in WAIT/CALC: the in-flight sample still completes. No new tick is issued until Enable returns high.
- Arithmetic:
  - d = ref − y, sign-extended to W+1 bits.
  - ek_new = sat(d). sat clamps to [−2^(W−1), 2^(W−1)−1], i.e. [−2048, 2047] for W = 12.
  - dek_new = sat(ek_new − ek), computed in W+1 bits.
  - On the CALC edge: ek ← ek_new, dek ← dek_new.
- missed: set as above; cleared when clr_missed = 1. If set and clear coincide, set wins.
- Reset asserted mid-operation: immediate return to reset state, including ek history (the next dek uses ek₋₁ = 0). A pending conversion is abandoned; a late adc_valid lands in IDLE and is ignored.

## Timing
- adc_start goes high the cycle after the tick edge and lasts 1 cycle.
- adc_valid sampled high at edge n:
  - capture at edge n.
  - ek, dek, en_k update at edge n+1 and are visible during cycle n+1 → n+2.
  - en_k falls at edge n+2.
- en_k is high for exactly 1 cycle per completed sample. ek/dek are stable from en_k high until the next en_k.
- The sample period is exactly DIV cycles while Enable stays high and conversions return within DIV−3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset low, then release with DIV = 10, Enable = 1 → first adc_start pulse on the cycle after the 10th enabled edge. adc_start spacing is 10 cycles; all outputs 0 before that.
- ref = 1000, adc_data = 200, adc_valid 3 cycles after adc_start → ek = 800, dek = 800, en_k high for 1 cycle exactly 1 edge after capture. Then adc_data = 1200 → ek = −200, dek = −1000.
- Saturation:
  - ref = 2047, adc_data = −2048 → ek = 2047.
  - ref = −2048, adc_data = 2047 → ek = −2048.
  - Previous ek = 800, new ek = −2000 → dek = −2048.
- Timeout: no adc_valid for a full period → missed = 1 and a second adc_start pulse. adc_valid then completes normally. Check the clr_missed set/clear priority case → missed stays 1.
- adc_valid coincident with a tick in WAIT → sample accepted, missed stays 0. A stray adc_valid in IDLE → no en_k, outputs unchanged.
- Reset pulsed low while in WAIT → all outputs 0 immediately, counter restarts. Enable low for 20 cycles → no adc_start, counter holds its value.
